// File: rtl/iir2_mch_if.sv
// Sample stream bundle for iir2_mch: tagged input samples in, tagged filtered samples out.
interface iir2_mch_if #(
  parameter int W   = 9,
  parameter int CHW = 2
);
  logic signed [W-1:0] din;
  logic                vin;
  logic [CHW-1:0]      ch_in;
  logic signed [W-1:0] dout;
  logic [CHW-1:0]      ch_out;
  logic                vout;

  modport master (output din, vin, ch_in, input dout, ch_out, vout);
  modport slave  (input din, vin, ch_in, output dout, ch_out, vout);
endinterface

// File: rtl/iir2_mch.sv
// Time-multiplexed direct-form-II biquad shared by CH channels with common coefficients.
// Input register -> per-channel state read/modify/write -> feedforward sum into output register.
module iir2_mch #(
  parameter int W  = 9,
  parameter int CH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  iir2_mch_if.slave           st,
  input  logic signed [W-1:0] a1_i,
  input  logic signed [W-1:0] a2_i,
  input  logic signed [W-1:0] b0_i,
  input  logic signed [W-1:0] b1_i,
  input  logic signed [W-1:0] b2_i,
  input  logic                coef_ld_i,
  input  logic                clr_i,
  output logic                busy_o,
  output logic                ld_err_o
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
  localparam int AW  = W + 2;
  localparam int PW  = 2 * W;

  // Q1.(W-1) product rescaled with floor; the result always fits in W+2 bits.
  function automatic logic signed [AW-1:0] mul_sh(input logic signed [W-1:0] c,
                                                  input logic signed [W-1:0] v);
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] ps;
    p  = PW'(c) * PW'(v);
    ps = p >>> (W - 1);
    return ps[AW-1:0];
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [AW-1:0] s);
    if (s[AW-1:W-1] == {3{s[AW-1]}}) return s[W-1:0];
    else if (s[AW-1])                return {1'b1, {(W-1){1'b0}}};
    else                             return {1'b0, {(W-1){1'b1}}};
  endfunction

  logic signed [W-1:0] a1_q, a2_q, b0_q, b1_q, b2_q;
  logic                vld_p0_q, vld_p1_q, vout_q, ld_err_q;
  logic signed [W-1:0] din_p0_q;
  logic [CHW-1:0]      ch_p0_q, ch_p1_q, ch_out_q;
  logic signed [W-1:0] w_p1_q, w1_p1_q, w2_p1_q, dout_q;
  logic signed [W-1:0] w1_q [CH];
  logic signed [W-1:0] w2_q [CH];
  logic signed [W-1:0] w1_rd, w2_rd, w_d, y_d;
  logic signed [AW-1:0] s_d, y_acc_d;
  logic                ch_ok, ld_ok;

  if (CH == (1 << CHW)) begin : g_full
    assign ch_ok = 1'b1;
  end else begin : g_part
    assign ch_ok = ({1'b0, st.ch_in} < (CHW + 1)'(CH));
  end

  assign busy_o = vld_p0_q | vld_p1_q;
  assign ld_ok  = ~busy_o & ~st.vin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q     <= '0;
      a2_q     <= '0;
      b0_q     <= '0;
      b1_q     <= '0;
      b2_q     <= '0;
      ld_err_q <= 1'b0;
    end else begin
      ld_err_q <= coef_ld_i & ~ld_ok;
      if (coef_ld_i && ld_ok) begin
        a1_q <= a1_i;
        a2_q <= a2_i;
        b0_q <= b0_i;
        b1_q <= b1_i;
        b2_q <= b2_i;
      end
    end
  end

  // Input register: out-of-range channels never become valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      vld_p0_q <= st.vin & ch_ok;
      vld_p1_q <= vld_p0_q;
    end
  end

  always_ff @(posedge clk) begin
    if (st.vin) begin
      din_p0_q <= st.din;
      ch_p0_q  <= st.ch_in;
    end
  end

  // Stage 1: recursive part; state is read and written back in the same cycle.
  assign w1_rd = w1_q[ch_p0_q];
  assign w2_rd = w2_q[ch_p0_q];
  assign s_d   = AW'(din_p0_q) - mul_sh(a1_q, w1_rd) - mul_sh(a2_q, w2_rd);
  assign w_d   = sat(s_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        w1_q[i] <= '0;
        w2_q[i] <= '0;
      end
    end else if (clr_i) begin
      for (int i = 0; i < CH; i++) begin
        w1_q[i] <= '0;
        w2_q[i] <= '0;
      end
    end else if (vld_p0_q) begin
      w1_q[ch_p0_q] <= w_d;
      w2_q[ch_p0_q] <= w1_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0_q) begin
      w_p1_q  <= w_d;
      w1_p1_q <= w1_rd;
      w2_p1_q <= w2_rd;
      ch_p1_q <= ch_p0_q;
    end
  end

  // Stage 2: feedforward sum into the output register, which holds while idle.
  assign y_acc_d = mul_sh(b0_q, w_p1_q) + mul_sh(b1_q, w1_p1_q) + mul_sh(b2_q, w2_p1_q);
  assign y_d     = sat(y_acc_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vout_q   <= 1'b0;
      dout_q   <= '0;
      ch_out_q <= '0;
    end else begin
      vout_q <= vld_p1_q;
      if (vld_p1_q) begin
        dout_q   <= y_d;
        ch_out_q <= ch_p1_q;
      end
    end
  end

  assign st.dout   = dout_q;
  assign st.ch_out = ch_out_q;
  assign st.vout   = vout_q;
  assign ld_err_o  = ld_err_q;
endmodule

// File: tb/tb_iir2_mch.sv
// Bench for iir2_mch: directed scenarios plus a randomized run against an integer reference model.
module tb_iir2_mch;
  localparam int W    = 9;
  localparam int CH   = 4;
  localparam int CHW  = 2;
  localparam int CH5  = 5;
  localparam int CHW5 = 3;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [W-1:0] a1, a2, b0, b1, b2;
  logic coef_ld, clr, busy, ld_err, busy5, ld_err5;

  always #5 clk = ~clk;

  iir2_mch_if #(.W(W), .CHW(CHW))  m();
  iir2_mch_if #(.W(W), .CHW(CHW5)) m5();

  iir2_mch #(.W(W), .CH(CH)) dut (
    .clk(clk), .rst_n(rst_n), .st(m),
    .a1_i(a1), .a2_i(a2), .b0_i(b0), .b1_i(b1), .b2_i(b2),
    .coef_ld_i(coef_ld), .clr_i(clr), .busy_o(busy), .ld_err_o(ld_err)
  );

  iir2_mch #(.W(W), .CH(CH5)) dut5 (
    .clk(clk), .rst_n(rst_n), .st(m5),
    .a1_i(a1), .a2_i(a2), .b0_i(b0), .b1_i(b1), .b2_i(b2),
    .coef_ld_i(coef_ld), .clr_i(clr), .busy_o(busy5), .ld_err_o(ld_err5)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int got_ch[$], got_y[$], got5_ch[$], got5_y[$], exp_ch[$], exp_y[$];
  int mw1[CH], mw2[CH];
  int ma1, ma2, mb0, mb1, mb2;

  always @(negedge clk) begin
    if (m.vout === 1'b1) begin
      got_ch.push_back(int'(m.ch_out));
      got_y.push_back(int'(m.dout));
    end
    if (m5.vout === 1'b1) begin
      got5_ch.push_back(int'(m5.ch_out));
      got5_y.push_back(int'(m5.dout));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: spec arithmetic on plain integers.
  function automatic int pm(int c, int v);
    return (c * v) >>> (W - 1);
  endfunction

  function automatic int satm(int s);
    if (s > MAXV) return MAXV;
    if (s < MINV) return MINV;
    return s;
  endfunction

  task automatic model_push(input int ch, input int x);
    int w, y;
    w = satm(x - pm(ma1, mw1[ch]) - pm(ma2, mw2[ch]));
    y = satm(pm(mb0, w) + pm(mb1, mw1[ch]) + pm(mb2, mw2[ch]));
    mw2[ch] = mw1[ch];
    mw1[ch] = w;
    exp_ch.push_back(ch);
    exp_y.push_back(y);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_got();
    got_ch.delete(); got_y.delete(); got5_ch.delete(); got5_y.delete();
    exp_ch.delete(); exp_y.delete();
  endtask

  task automatic push(input int ch, input int x);
    m.vin = 1'b1;
    m.ch_in = ch[CHW-1:0];
    m.din = x[W-1:0];
    tick();
    m.vin = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic load(input int xa1, input int xa2, input int xb0, input int xb1, input int xb2);
    a1 = xa1[W-1:0]; a2 = xa2[W-1:0]; b0 = xb0[W-1:0]; b1 = xb1[W-1:0]; b2 = xb2[W-1:0];
    coef_ld = 1'b1;
    tick();
    coef_ld = 1'b0;
    ma1 = xa1; ma2 = xa2; mb0 = xb0; mb1 = xb1; mb2 = xb2;
    total_cnt++;
    if (ld_err !== 1'b0) $display("FAIL load_accept ld_err=%b want 0", ld_err);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    int ey;
    m.vin = 0; m.din = '0; m.ch_in = '0; m5.vin = 0; m5.din = '0; m5.ch_in = '0;
    a1 = '0; a2 = '0; b0 = '0; b1 = '0; b2 = '0; coef_ld = 0; clr = 0;
    rst_n = 1'b0;
    repeat (3) tick();
    total_cnt += 5;
    if (m.dout !== '0) $display("FAIL rst_dout got %0d want 0", m.dout); else pass_cnt++;
    if (m.ch_out !== '0) $display("FAIL rst_ch_out got %0d want 0", m.ch_out); else pass_cnt++;
    if (m.vout !== 1'b0) $display("FAIL rst_vout got %b want 0", m.vout); else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass_cnt++;
    if (ld_err !== 1'b0) $display("FAIL rst_ld_err got %b want 0", ld_err); else pass_cnt++;
    rst_n = 1'b1;
    tick();
    clear_got();
    push(0, 100);
    repeat (5) tick();
    ey = (got_y.size() == 1) ? got_y[0] : -999;
    total_cnt++;
    if (ey !== 0) $display("FAIL rst_zero_coef got %0d (n=%0d) want 0", ey, got_y.size());
    else pass_cnt++;
  endtask

  task automatic test_impulse();
    load(0, 0, 255, 0, 0);
    clear_got();
    push(0, 255);
    total_cnt += 5;
    if (m.vout !== 1'b0) $display("FAIL imp_lat1 vout=%b want 0", m.vout); else pass_cnt++;
    tick();
    if (m.vout !== 1'b0) $display("FAIL imp_lat2 vout=%b want 0", m.vout); else pass_cnt++;
    tick();
    if (m.vout !== 1'b1 || m.dout !== 9'sd254 || m.ch_out !== 2'd0)
      $display("FAIL imp_first got v%b ch%0d %0d want v1 ch0 254", m.vout, m.ch_out, m.dout);
    else pass_cnt++;
    push(0, 0);
    if (m.vout !== 1'b0 || m.dout !== 9'sd254)
      $display("FAIL imp_hold got v%b %0d want v0 254", m.vout, m.dout);
    else pass_cnt++;
    tick();
    tick();
    if (m.vout !== 1'b1 || m.dout !== 9'sd0)
      $display("FAIL imp_zero got v%b %0d want v1 0", m.vout, m.dout);
    else pass_cnt++;
    repeat (3) tick();
    clear_got();
  endtask

  task automatic test_saturation();
    int ey[2] = '{199, 254};
    load(-256, 0, 255, 0, 0);
    clear_got();
    push(2, 200);
    push(2, 200);
    repeat (5) tick();
    total_cnt++;
    if (got_y.size() != 2) $display("FAIL sat_count got %0d want 2", got_y.size()); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      int gy, gc;
      gy = (i < got_y.size()) ? got_y[i] : -999;
      gc = (i < got_ch.size()) ? got_ch[i] : -1;
      total_cnt++;
      if (gy != ey[i] || gc != 2) $display("FAIL sat[%0d] got ch%0d %0d want ch2 %0d", i, gc, gy, ey[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_isolation();
    int ey[8] = '{99, -50, 199, -100, 254, -150, 254, -200};
    pulse_clr();
    clear_got();
    for (int k = 0; k < 4; k++) begin
      m.vin = 1'b1; m.ch_in = 2'd0; m.din = 9'sd100;  tick();
      m.vin = 1'b1; m.ch_in = 2'd1; m.din = -9'sd50;  tick();
    end
    m.vin = 1'b0;
    repeat (5) tick();
    total_cnt++;
    if (got_y.size() != 8) $display("FAIL iso_count got %0d want 8", got_y.size()); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      int gy, gc;
      gy = (i < got_y.size()) ? got_y[i] : -999;
      gc = (i < got_ch.size()) ? got_ch[i] : -1;
      total_cnt++;
      if (gy != ey[i] || gc != (i % 2)) $display("FAIL iso[%0d] got ch%0d %0d want ch%0d %0d", i, gc, gy, i % 2, ey[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_coef_guard();
    int ey[3] = '{99, 199, 50};
    clear_got();
    push(3, 100);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL guard_busy got %b want 1", busy); else pass_cnt++;
    a1 = '0; a2 = '0; b0 = 9'sd128; b1 = '0; b2 = '0;
    coef_ld = 1'b1;
    tick();
    coef_ld = 1'b0;
    total_cnt += 4;
    if (ld_err !== 1'b1) $display("FAIL guard_err_busy got %b want 1", ld_err); else pass_cnt++;
    tick();
    if (ld_err !== 1'b0) $display("FAIL guard_err_once got %b want 0", ld_err); else pass_cnt++;
    repeat (4) tick();
    m.vin = 1'b1; m.ch_in = 2'd3; m.din = 9'sd100; coef_ld = 1'b1;
    tick();
    m.vin = 1'b0; coef_ld = 1'b0;
    if (ld_err !== 1'b1) $display("FAIL guard_err_vin got %b want 1", ld_err); else pass_cnt++;
    tick();
    if (ld_err !== 1'b0) $display("FAIL guard_err_vin_once got %b want 0", ld_err); else pass_cnt++;
    repeat (4) tick();
    load(0, 0, 128, 0, 0);
    push(3, 100);
    repeat (5) tick();
    total_cnt++;
    if (got_y.size() != 3) $display("FAIL guard_count got %0d want 3", got_y.size()); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      int gy;
      gy = (i < got_y.size()) ? got_y[i] : -999;
      total_cnt++;
      if (gy != ey[i]) $display("FAIL guard[%0d] got %0d want %0d", i, gy, ey[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_clr();
    int ey[6] = '{199, 254, 199, 254, 199, 254};
    load(-256, 0, 255, 0, 0);
    pulse_clr();
    clear_got();
    push(0, 200);
    push(0, 200);
    repeat (4) tick();
    pulse_clr();
    push(0, 200);
    repeat (4) tick();
    // First sample is in the state stage while clr and the second sample arrive together.
    m.vin = 1'b1; m.ch_in = 2'd0; m.din = 9'sd200;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m.vin = 1'b0;
    push(0, 200);
    repeat (5) tick();
    total_cnt++;
    if (got_y.size() != 6) $display("FAIL clr_count got %0d want 6", got_y.size()); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      int gy;
      gy = (i < got_y.size()) ? got_y[i] : -999;
      total_cnt++;
      if (gy != ey[i]) $display("FAIL clr[%0d] got %0d want %0d", i, gy, ey[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_drop();
    int gy, gc;
    load(0, 0, 255, 0, 0);
    clear_got();
    m5.vin = 1'b1; m5.ch_in = 3'd5; m5.din = 9'sd100;
    tick();
    total_cnt += 3;
    if (busy5 !== 1'b0) $display("FAIL drop_busy5 got %b want 0", busy5); else pass_cnt++;
    m5.ch_in = 3'd7;
    tick();
    m5.vin = 1'b0;
    if (busy5 !== 1'b0) $display("FAIL drop_busy7 got %b want 0", busy5); else pass_cnt++;
    repeat (5) tick();
    if (got5_y.size() != 0) $display("FAIL drop_vout got %0d outputs want 0", got5_y.size()); else pass_cnt++;
    m5.vin = 1'b1; m5.ch_in = 3'd4; m5.din = 9'sd255;
    tick();
    m5.vin = 1'b0;
    repeat (5) tick();
    gy = (got5_y.size() == 1) ? got5_y[0] : -999;
    gc = (got5_ch.size() == 1) ? got5_ch[0] : -1;
    total_cnt++;
    if (gy != 254 || gc != 4) $display("FAIL drop_valid4 got ch%0d %0d want ch4 254", gc, gy);
    else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    int gy0, gy1;
    load(-256, 0, 255, 0, 0);
    pulse_clr();
    clear_got();
    for (int k = 0; k < 3; k++) begin
      m.vin = 1'b1; m.ch_in = 2'd0; m.din = 9'sd200;
      tick();
    end
    m.vin = 1'b0;
    rst_n = 1'b0;
    #1;
    total_cnt += 4;
    if (m.vout !== 1'b0) $display("FAIL mid_rst_vout got %b want 0", m.vout); else pass_cnt++;
    if (m.dout !== '0) $display("FAIL mid_rst_dout got %0d want 0", m.dout); else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", busy); else pass_cnt++;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    if (got_y.size() != 0) $display("FAIL mid_stale got %0d outputs want 0", got_y.size()); else pass_cnt++;
    push(1, 200);
    repeat (5) tick();
    load(-256, 0, 255, 0, 0);
    push(0, 200);
    repeat (5) tick();
    gy0 = (got_y.size() == 2) ? got_y[0] : -999;
    gy1 = (got_y.size() == 2) ? got_y[1] : -999;
    total_cnt += 2;
    if (gy0 != 0) $display("FAIL mid_coef_zero got %0d want 0", gy0); else pass_cnt++;
    if (gy1 != 199) $display("FAIL mid_state_zero got %0d want 199", gy1); else pass_cnt++;
  endtask

  task automatic test_random();
    pulse_clr();
    for (int c = 0; c < CH; c++) begin mw1[c] = 0; mw2[c] = 0; end
    clear_got();
    for (int blk = 0; blk < 2; blk++) begin
      load(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
           int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
           int'($urandom_range(0, 511)) - 256);
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          int ch, x;
          ch = int'($urandom_range(0, CH - 1));
          x  = int'($urandom_range(0, 511)) - 256;
          m.vin = 1'b1; m.ch_in = ch[CHW-1:0]; m.din = x[W-1:0];
          model_push(ch, x);
        end else begin
          m.vin = 1'b0;
        end
        tick();
      end
      m.vin = 1'b0;
      repeat (5) tick();
    end
    total_cnt++;
    if (got_y.size() != exp_y.size()) $display("FAIL rnd_count got %0d want %0d", got_y.size(), exp_y.size());
    else pass_cnt++;
    for (int i = 0; i < exp_y.size(); i++) begin
      int gy, gc;
      gy = (i < got_y.size()) ? got_y[i] : -999;
      gc = (i < got_ch.size()) ? got_ch[i] : -1;
      total_cnt++;
      if (gy != exp_y[i] || gc != exp_ch[i])
        $display("FAIL rnd[%0d] got ch%0d %0d want ch%0d %0d", i, gc, gy, exp_ch[i], exp_y[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_saturation();
    test_isolation();
    test_coef_guard();
    test_clr();
    test_drop();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
